// File: rtl/pair_bank_reader.sv
// ---------------------------------------------------------------------------
// pair_bank_reader
//
// Purpose:
//    Drains a previously loaded even/odd tuple-pair bank set back out as an
//    address-ordered stream of tuple pairs. The bank layout matches the input
//    loader: pair address a lives in the even bank when a is even and in the
//    odd bank when a is odd, both at row a>>1. One access reads a whole row
//    (both banks in parallel) into a two-entry row buffer, which is then
//    presented one pair per valid/ready handshake.
//
// Parameters:
//    DATA_WIDTH      width of each tuple field (first, second)
//    BANK_ADDR_WIDTH pair-address width used when the banks were loaded
//                    (must be at least 2)
//
// Ports:
//    clock            single clock, everything on posedge
//    reset            synchronous, active-high
//    start_in         one-cycle start pulse, honoured only while idle
//    base_addr_in     first pair address of the job (even)
//    count_in         number of pairs to drain, 0 .. 2^BANK_ADDR_WIDTH
//    rd_en_out        read strobe shared by both banks
//    rd_addr_out      pair address of the even entry of the row being read
//    even_rd_data_in  even-bank read data, one cycle after rd_en_out
//    odd_rd_data_in   odd-bank read data, one cycle after rd_en_out
//    pair_out         tuple pair {first, second}
//    pair_valid_out   pair_out is valid
//    pair_ready_in    consumer accepts pair_out this cycle
//    busy_out         a job is in flight
//    done_out         one-cycle pulse once the job has finished
// ---------------------------------------------------------------------------
module pair_bank_reader #(
   parameter int DATA_WIDTH      = 16,
   parameter int BANK_ADDR_WIDTH = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start_in,
   input  logic [BANK_ADDR_WIDTH-1:0]   base_addr_in,
   input  logic [BANK_ADDR_WIDTH:0]     count_in,
   output logic                         rd_en_out,
   output logic [BANK_ADDR_WIDTH-1:0]   rd_addr_out,
   input  logic [2*DATA_WIDTH-1:0]      even_rd_data_in,
   input  logic [2*DATA_WIDTH-1:0]      odd_rd_data_in,
   output logic [2*DATA_WIDTH-1:0]      pair_out,
   output logic                         pair_valid_out,
   input  logic                         pair_ready_in,
   output logic                         busy_out,
   output logic                         done_out
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] first;
      logic [DATA_WIDTH-1:0] second;
   } tuple_pair_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_EMIT_EVEN,
      ST_EMIT_ODD,
      ST_DONE
   } state_t;

   localparam logic [BANK_ADDR_WIDTH-1:0] ROW_STEP = BANK_ADDR_WIDTH'(2);
   localparam logic [BANK_ADDR_WIDTH:0]   ONE_PAIR = (BANK_ADDR_WIDTH + 1)'(1);

   state_t                       state_q,     state_d;
   logic [BANK_ADDR_WIDTH-1:0]   addr_q,      addr_d;
   logic [BANK_ADDR_WIDTH:0]     remaining_q, remaining_d;
   tuple_pair_t                  evenBuf_q,   evenBuf_d;
   tuple_pair_t                  oddBuf_q,    oddBuf_d;

   logic [BANK_ADDR_WIDTH-1:0]   startAddr;
   logic [BANK_ADDR_WIDTH-1:0]   nextRowAddr;
   logic                         lastPair;

   // The even entry of a row always sits at an even pair address, so bit 0
   // of the base is forced low rather than trusted.
   assign startAddr   = {base_addr_in[BANK_ADDR_WIDTH-1:1], 1'b0};

   // Row addresses wrap naturally modulo 2^BANK_ADDR_WIDTH.
   assign nextRowAddr = addr_q + ROW_STEP;

   // The pair currently on offer is the final one of the job.
   assign lastPair    = (remaining_q == ONE_PAIR);

   // State and datapath registers. Reset abandons any job in flight: the FSM
   // returns to idle without a done pulse and the row buffer is cleared, so
   // stale bank data can never be presented afterwards.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         evenBuf_q   <= '0;
         oddBuf_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         evenBuf_q   <= evenBuf_d;
         oddBuf_q    <= oddBuf_d;
      end
   end

   // Next-state and output decode. The read strobe is combinational so that
   // the first row read goes out in the same cycle as the start pulse, and
   // the next row read goes out in the same cycle the odd entry is accepted.
   // That keeps the bank one cycle ahead of the buffer and gives a steady
   // two pairs per three cycles with the consumer always ready.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      remaining_d    = remaining_q;
      evenBuf_d      = evenBuf_q;
      oddBuf_d       = oddBuf_q;
      rd_en_out      = 1'b0;
      rd_addr_out    = addr_q;
      pair_out       = '0;
      pair_valid_out = 1'b0;
      done_out       = 1'b0;
      busy_out       = (state_q != ST_IDLE);

      unique case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               if (count_in != '0) begin
                  rd_en_out   = 1'b1;
                  rd_addr_out = startAddr;
                  addr_d      = startAddr;
                  remaining_d = count_in;
                  state_d     = ST_WAIT;
               end else begin
                  state_d     = ST_DONE;
               end
            end
         end

         ST_WAIT: begin
            evenBuf_d = even_rd_data_in;
            oddBuf_d  = odd_rd_data_in;
            state_d   = ST_EMIT_EVEN;
         end

         ST_EMIT_EVEN: begin
            pair_valid_out = 1'b1;
            pair_out       = evenBuf_q;
            if (pair_ready_in) begin
               remaining_d = remaining_q - ONE_PAIR;
               state_d     = lastPair ? ST_DONE : ST_EMIT_ODD;
            end
         end

         ST_EMIT_ODD: begin
            pair_valid_out = 1'b1;
            pair_out       = oddBuf_q;
            if (pair_ready_in) begin
               remaining_d = remaining_q - ONE_PAIR;
               if (lastPair) begin
                  state_d = ST_DONE;
               end else begin
                  rd_en_out   = 1'b1;
                  rd_addr_out = nextRowAddr;
                  addr_d      = nextRowAddr;
                  state_d     = ST_WAIT;
               end
            end
         end

         // A start arriving in this cycle falls through unhonoured because
         // only the idle state looks at start_in.
         ST_DONE: begin
            done_out = 1'b1;
            state_d  = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pair_bank_reader.sv
// ---------------------------------------------------------------------------
// tb_pair_bank_reader
//
// Directed bench for pair_bank_reader with an 8-entry bank model. A table of
// jobs (base, count, ready pattern, expected read count and done timing) is
// replayed in a loop; reset-abort and start-on-done are hand-written
// sequences.
// ---------------------------------------------------------------------------
module tb_pair_bank_reader;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int PW = 2 * DW;

   logic            clock = 1'b0;
   logic            reset;
   logic            start_in;
   logic [AW-1:0]   base_addr_in;
   logic [AW:0]     count_in;
   logic            rd_en_out;
   logic [AW-1:0]   rd_addr_out;
   logic [PW-1:0]   even_rd_data_in;
   logic [PW-1:0]   odd_rd_data_in;
   logic [PW-1:0]   pair_out;
   logic            pair_valid_out;
   logic            pair_ready_in;
   logic            busy_out;
   logic            done_out;

   pair_bank_reader #(
      .DATA_WIDTH      (DW),
      .BANK_ADDR_WIDTH (AW)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start_in        (start_in),
      .base_addr_in    (base_addr_in),
      .count_in        (count_in),
      .rd_en_out       (rd_en_out),
      .rd_addr_out     (rd_addr_out),
      .even_rd_data_in (even_rd_data_in),
      .odd_rd_data_in  (odd_rd_data_in),
      .pair_out        (pair_out),
      .pair_valid_out  (pair_valid_out),
      .pair_ready_in   (pair_ready_in),
      .busy_out        (busy_out),
      .done_out        (done_out)
   );

   always #5 clock = ~clock;

   // Bank contents indexed by pair address.
   logic [PW-1:0] bankMem [0:7];

   // Bank pair model: data appears exactly one cycle after the strobe; any
   // other cycle returns a poison value so mistimed captures show up.
   always @(posedge clock) begin
      if (rd_en_out) begin
         even_rd_data_in <= bankMem[rd_addr_out];
         odd_rd_data_in  <= bankMem[rd_addr_out + 3'd1];
      end else begin
         even_rd_data_in <= 16'hDEAD;
         odd_rd_data_in  <= 16'hBEEF;
      end
   end

   int compared   = 0;
   int mismatched = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   count;
      int            readyMode;
      bit            rePulse;
      int            expReads;
      int            expDoneCyc;
      string         tag;
   } vec_t;

   function automatic vec_t mkVec(input logic [AW-1:0] base, input logic [AW:0] count,
                                  input int readyMode, input bit rePulse,
                                  input int expReads, input int expDoneCyc,
                                  input string tag);
      vec_t v;
      v.base       = base;
      v.count      = count;
      v.readyMode  = readyMode;
      v.rePulse    = rePulse;
      v.expReads   = expReads;
      v.expDoneCyc = expDoneCyc;
      v.tag        = tag;
      return v;
   endfunction

   // Mode 0: always ready. Mode 1: ready pattern 1,0,0,1 repeating.
   function automatic logic readyFor(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      return ((cyc % 4) == 0) || ((cyc % 4) == 3);
   endfunction

   logic [PW-1:0] gotPairs [$];
   logic [AW-1:0] gotAddrs [$];

   // Runs one job from its start cycle (cyc 0) until one cycle after done,
   // recording read addresses and accepted pairs and checking that stalled
   // pairs hold stable.
   task automatic applyStimulus(input vec_t v, output int doneCyc, output int doneCount,
                                output logic busyEarly, output logic busyAfter,
                                output bit timedOut);
      bit            prevStall;
      bit            finished;
      logic [PW-1:0] prevPair;
      gotPairs.delete();
      gotAddrs.delete();
      doneCyc   = -1;
      doneCount = 0;
      busyEarly = 1'b0;
      busyAfter = 1'b1;
      timedOut  = 1'b1;
      prevStall = 1'b0;
      finished  = 1'b0;
      prevPair  = '0;
      @(negedge clock);
      start_in      = 1'b1;
      base_addr_in  = v.base;
      count_in      = v.count;
      pair_ready_in = readyFor(v.readyMode, 0);
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         if (cyc > 0) begin
            @(negedge clock);
            start_in      = v.rePulse && (cyc == 3);
            base_addr_in  = v.rePulse ? 3'd6 : v.base;
            count_in      = v.rePulse ? 4'd2 : v.count;
            pair_ready_in = readyFor(v.readyMode, cyc);
         end
         #1;
         if (prevStall) begin
            checkOutput({v.tag, "_hold_valid"}, 32'(pair_valid_out), 32'd1);
            checkOutput({v.tag, "_hold_pair"}, 32'(pair_out), 32'(prevPair));
         end
         if (rd_en_out) gotAddrs.push_back(rd_addr_out);
         if (pair_valid_out && pair_ready_in) gotPairs.push_back(pair_out);
         if (cyc == 1) busyEarly = busy_out;
         if (doneCyc >= 0 && cyc == doneCyc + 1) begin
            busyAfter = busy_out;
            finished  = 1'b1;
            timedOut  = 1'b0;
         end
         if (done_out) begin
            doneCount++;
            if (doneCyc < 0) doneCyc = cyc;
         end
         prevStall = pair_valid_out && !pair_ready_in;
         prevPair  = pair_out;
      end
      start_in = 1'b0;
   endtask

   // Compares a finished job against the bank contents and the table entry.
   task automatic checkJob(input vec_t v, input int doneCyc, input int doneCount,
                           input logic busyEarly, input logic busyAfter, input bit timedOut);
      logic [AW-1:0] ea;
      checkOutput({v.tag, "_timeout"}, 32'(timedOut), 32'd0);
      checkOutput({v.tag, "_reads"}, 32'(gotAddrs.size()), 32'(v.expReads));
      for (int k = 0; k < gotAddrs.size(); k++) begin
         ea = v.base + AW'(2 * k);
         checkOutput({v.tag, "_rd_addr"}, 32'(gotAddrs[k]), 32'(ea));
      end
      checkOutput({v.tag, "_transfers"}, 32'(gotPairs.size()), 32'(v.count));
      for (int k = 0; k < gotPairs.size() && k < int'(v.count); k++) begin
         ea = v.base + AW'(k);
         checkOutput({v.tag, "_pair"}, 32'(gotPairs[k]), 32'(bankMem[ea]));
      end
      checkOutput({v.tag, "_done_pulses"}, 32'(doneCount), 32'd1);
      if (v.expDoneCyc >= 0)
         checkOutput({v.tag, "_done_cycle"}, 32'(doneCyc), 32'(v.expDoneCyc));
      if (v.count != '0)
         checkOutput({v.tag, "_busy_early"}, 32'(busyEarly), 32'd1);
      checkOutput({v.tag, "_busy_after"}, 32'(busyAfter), 32'd0);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_rd_en"},   32'(rd_en_out),      32'd0);
      checkOutput({tag, "_rd_addr"}, 32'(rd_addr_out),    32'd0);
      checkOutput({tag, "_pair"},    32'(pair_out),       32'd0);
      checkOutput({tag, "_valid"},   32'(pair_valid_out), 32'd0);
      checkOutput({tag, "_busy"},    32'(busy_out),       32'd0);
      checkOutput({tag, "_done"},    32'(done_out),       32'd0);
   endtask

   initial begin
      vec_t vecs [10];
      int   doneCyc;
      int   doneCount;
      logic busyEarly;
      logic busyAfter;
      bit   timedOut;
      logic sawBad;

      bankMem[0] = {8'd3,  8'd5};
      bankMem[1] = {8'd10, 8'd14};
      bankMem[2] = {8'd12, 8'd18};
      bankMem[3] = {8'd16, 8'd20};
      bankMem[4] = {8'd1,  8'd1};
      bankMem[5] = {8'd2,  8'd2};
      bankMem[6] = {8'd7,  8'd9};
      bankMem[7] = {8'd8,  8'd8};

      // base, count, ready mode, re-pulse, expected reads, done cycle (-1 = untimed)
      vecs[0] = mkVec(3'd0, 4'd8, 0, 1'b0, 4, 13, "full8");
      vecs[1] = mkVec(3'd0, 4'd5, 0, 1'b0, 3,  9, "odd5");
      vecs[2] = mkVec(3'd0, 4'd0, 0, 1'b0, 0,  1, "zero");
      vecs[3] = mkVec(3'd0, 4'd8, 1, 1'b0, 4, -1, "stall8");
      vecs[4] = mkVec(3'd0, 4'd8, 0, 1'b1, 4, 13, "repulse8");
      vecs[5] = mkVec(3'd6, 4'd4, 0, 1'b0, 2,  7, "wrap4");
      vecs[6] = mkVec(3'd4, 4'd8, 0, 1'b0, 4, 13, "wrap8");
      vecs[7] = mkVec(3'd2, 4'd1, 0, 1'b0, 1,  3, "single");
      vecs[8] = mkVec(3'd4, 4'd3, 0, 1'b0, 2,  6, "odd3");
      vecs[9] = mkVec(3'd4, 4'd2, 0, 1'b0, 1,  4, "after_reset");

      reset         = 1'b1;
      start_in      = 1'b0;
      base_addr_in  = '0;
      count_in      = '0;
      pair_ready_in = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      checkIdleOutputs("reset_state");
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i], doneCyc, doneCount, busyEarly, busyAfter, timedOut);
         checkJob(vecs[i], doneCyc, doneCount, busyEarly, busyAfter, timedOut);
      end

      // Reset on the third transfer cycle of a full job, then a fresh job.
      @(negedge clock);
      start_in      = 1'b1;
      base_addr_in  = 3'd0;
      count_in      = 4'd8;
      pair_ready_in = 1'b1;
      @(negedge clock);
      start_in = 1'b0;
      repeat (4) @(negedge clock);
      #1;
      checkOutput("rst_third_valid", 32'(pair_valid_out), 32'd1);
      checkOutput("rst_third_pair", 32'(pair_out), 32'(bankMem[2]));
      reset = 1'b1;
      @(negedge clock);
      #1;
      checkIdleOutputs("rst_abort");
      reset  = 1'b0;
      sawBad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         #1;
         sawBad = sawBad | done_out | pair_valid_out | rd_en_out | busy_out;
      end
      checkOutput("rst_quiet_after", 32'(sawBad), 32'd0);
      applyStimulus(vecs[9], doneCyc, doneCount, busyEarly, busyAfter, timedOut);
      checkJob(vecs[9], doneCyc, doneCount, busyEarly, busyAfter, timedOut);

      // Start pulse coinciding with done is ignored; the next cycle may start.
      @(negedge clock);
      start_in      = 1'b1;
      base_addr_in  = 3'd2;
      count_in      = 4'd2;
      pair_ready_in = 1'b1;
      @(negedge clock);
      start_in = 1'b0;
      repeat (3) @(negedge clock);
      start_in     = 1'b1;
      base_addr_in = 3'd0;
      count_in     = 4'd8;
      #1;
      checkOutput("sod_done_pulse", 32'(done_out), 32'd1);
      @(negedge clock);
      start_in = 1'b0;
      #1;
      checkOutput("sod_busy_ignored", 32'(busy_out), 32'd0);
      checkOutput("sod_rd_en_ignored", 32'(rd_en_out), 32'd0);
      @(negedge clock);
      start_in     = 1'b1;
      base_addr_in = 3'd0;
      count_in     = 4'd1;
      #1;
      checkOutput("sod_restart_rd_en", 32'(rd_en_out), 32'd1);
      checkOutput("sod_restart_addr", 32'(rd_addr_out), 32'd0);
      @(negedge clock);
      start_in = 1'b0;
      @(negedge clock);
      #1;
      checkOutput("sod_restart_valid", 32'(pair_valid_out), 32'd1);
      checkOutput("sod_restart_pair", 32'(pair_out), 32'(bankMem[0]));
      @(negedge clock);
      #1;
      checkOutput("sod_restart_done", 32'(done_out), 32'd1);

      repeat (2) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pair_bank_reader.md
Name: pair_bank_reader

Overview:
- Drains a previously loaded even/odd tuple-pair bank set, the same layout the input loader writes: pair address `a`, even bank holds even `a`, odd bank holds `a+1`, both at row `a>>1`.
- Reads one row per access (both banks in parallel) and serialises it into one `tuple_pair_t` per handshake on a valid/ready stream.
- The downstream consumer is the result checker / interval-merge stage.
- Sits between the ping/pong bank pair and any consumer that needs sorted pairs back in address order.

Parameters:
- DATA_WIDTH, `` `DATA_WIDTH ``: width of each `tuple_pair_t` field (`first`, `second`); a pair is 2*DATA_WIDTH bits.
- BANK_ADDR_WIDTH, `` `BANK_ADDR_WIDTH ``: pair-address width, same addressing used when loading the banks.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start_in  in  1  one-cycle pulse; latches base_addr_in and count_in; ignored unless idle.
- base_addr_in  in  BANK_ADDR_WIDTH  first pair address; bit 0 must be 0.
- count_in  in  BANK_ADDR_WIDTH+1  number of pairs to drain (0..2^BANK_ADDR_WIDTH).
- rd_en_out  out  1  bank read strobe, shared by both banks.
- rd_addr_out  out  BANK_ADDR_WIDTH  pair address of the even entry of the row (LSB always 0).
- even_rd_data_in  in  2*DATA_WIDTH  even-bank data, valid exactly 1 cycle after rd_en_out.
- odd_rd_data_in  in  2*DATA_WIDTH  odd-bank data, same timing.
- pair_out  out  2*DATA_WIDTH  `tuple_pair_t` {first, second}.
- pair_valid_out  out  1  pair_out valid.
- pair_ready_in  in  1  consumer accepts; a transfer occurs when valid&&ready.
- busy_out  out  1  high from the cycle after an accepted start until done.
- done_out  out  1  one-cycle pulse after the final transfer (or after start with count 0).

Behaviour:
- Reset values: rd_en_out=0, rd_addr_out=0, pair_out=0, pair_valid_out=0, busy_out=0, done_out=0; FSM=IDLE; row buffer cleared.
- Reset asserted mid-operation: abort immediately and return to IDLE. No done pulse. Any read data arriving after reset is discarded.
- FSM states:
  - IDLE: on start_in with count_in≠0, latch the inputs, assert rd_en_out with rd_addr_out=base_addr_in the same cycle (combinational from start), set remaining=count_in, then go to WAIT. With count_in=0: go to DONE, and no read is issued.
  - WAIT: capture even_rd_data_in and odd_rd_data_in into the 2-entry row buffer, then go to EMIT_EVEN.
  - EMIT_EVEN: pair_valid_out=1, pair_out=buffered even pair. On transfer, decrement remaining.
    - remaining becomes 0: go to DONE.
    - otherwise: go to EMIT_ODD.
  - EMIT_ODD: pair_valid_out=1, pair_out=buffered odd pair. On transfer, decrement remaining.
    - remaining becomes 0: go to DONE.
    - otherwise: assert rd_en_out that cycle with rd_addr_out=previous+2, then go to WAIT.
  - DONE: done_out=1 for exactly one cycle, busy_out=0 next, return to IDLE.
- Odd count: the final row emits only its even pair; the odd entry is read but never presented.
- Backpressure: while valid&&!ready, pair_out and pair_valid_out hold stable. Valid never drops without a transfer.
- Steady-state throughput with ready held high: 2 pairs per 3 cycles.
- Latency: first pair_valid_out is 2 cycles after the start_in cycle.
- Address wrap: rd_addr_out increments modulo 2^BANK_ADDR_WIDTH.
- Exactly ceil(count/2) read strobes per job.
- start_in while busy is ignored; latched values are unaffected.
- start_in on the same cycle as done_out is also ignored; a new job may start from the following cycle.
- rd_en_out is never asserted outside IDLE (start cycle) and EMIT_ODD (final-of-row transfer cycle).

Test Plan:
- Bank holds pairs 0..7 = (3,5),(10,14),(12,18),(16,20),(1,1),(2,2),(7,9),(8,8); base 0, count 8, ready=1 → those 8 pairs in order; 4 reads at addresses 0,2,4,6; done_out 1 cycle after 8th transfer; 12 cycles start→last valid.
- Same bank, count 5 → pairs 0..4 only; 3 reads; odd entry of row 2 never appears; done_out follows the 5th transfer.
- count 0 → no rd_en_out; pair_valid_out stays 0; done_out pulses 1 cycle after start, then busy_out=0.
- ready toggled 1,0,0,1,... during the count 8 job → every pair held stable while stalled; no pair lost or duplicated; order unchanged; total transfers=8.
- Reset asserted on the 3rd transfer cycle → next cycle all outputs at reset values, no done_out; a fresh start with base 4, count 2 yields (1,1),(2,2).
- start_in re-pulsed mid-job with base 6 → ignored; original sequence completes unchanged.
